// File: rtl/mat_pkg.sv
// Shared sizes and types for the per-core matrix buffer.
// Two LANES-wide beats fill one ROWS x COLS matrix.
package mat_pkg;

    localparam int EW    = 8;
    localparam int LANES = 32;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH);
    localparam int RIW   = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int LW    = $clog2(LANES);

    typedef enum logic [1:0] {
        EMPTY,
        READY,
        STREAM
    } buf_state_e;

    typedef logic [EW-1:0]      elem_t;
    typedef logic [COLS*EW-1:0] row_t;

endpackage

// File: rtl/mat_buf_ram.sv
// Matrix storage: one half-matrix-wide write port and one combinational
// whole-row read port.
module mat_buf_ram
    import mat_pkg::*;
(
    input  logic               clk,
    input  logic               we_i,
    input  logic               h_i,
    input  logic [LANES*EW-1:0] wdata_i,
    input  logic [RIW-1:0]     rd_row_i,
    output row_t               rd_data_o
);

    elem_t mem_q [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the parent's
    // half flags, so clearing the storage would only cost logic.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < LANES; i++) begin
                mem_q[{h_i, LW'(i)}] <= wdata_i[i*EW +: EW];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int c = 0; c < COLS; c++) begin
            rd_data_o[c*EW +: EW] = mem_q[{rd_row_i, CW'(c)}];
        end
    end

endmodule

// File: rtl/mat_core_buf.sv
// Per-core matrix buffer: captures two half-matrix beats, then replays
// the matrix row by row over a valid/ready stream.
module mat_core_buf
    import mat_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mat_clr,
    input  logic                mat_we,
    input  logic [AW-1:0]       mat_a,
    input  logic [LANES*EW-1:0] mat_d,
    input  logic                rd_start,
    output logic                row_valid,
    input  logic                row_ready,
    output row_t                row_data,
    output logic [RIW-1:0]      row_idx,
    output logic                row_last,
    output logic                loaded,
    output logic                busy,
    output logic                err
);

    buf_state_e     state_q, state_d;
    logic [1:0]     half_vld_q, half_vld_d;
    logic           loaded_q, loaded_d;
    logic           err_q, err_d;
    logic           row_valid_q, row_valid_d;
    logic [RIW-1:0] row_idx_q, row_idx_d;
    row_t           row_data_q, row_data_d;

    row_t           ram_row;
    logic [RIW-1:0] rd_row;
    logic           addr_ok, wr_ok, wr_bad, start, hs;

    assign addr_ok = (mat_a[AW-2:0] == '0);
    assign wr_ok   = mat_we && !mat_clr && addr_ok && (state_q != STREAM);
    assign wr_bad  = mat_we && !mat_clr && (!addr_ok || (state_q == STREAM));
    assign start   = rd_start && !mat_clr && (state_q == READY);
    assign hs      = row_valid_q && row_ready;
    // Row 0 on a fresh start, otherwise the row after the one being accepted.
    assign rd_row  = start ? '0 : row_idx_q + 1'b1;

    mat_buf_ram u_ram (
        .clk       (clk),
        .we_i      (wr_ok),
        .h_i       (mat_a[AW-1]),
        .wdata_i   (mat_d),
        .rd_row_i  (rd_row),
        .rd_data_o (ram_row)
    );

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no
        // path through the branches below can infer a latch.
        state_d     = state_q;
        half_vld_d  = half_vld_q;
        err_d       = err_q;
        row_valid_d = row_valid_q;
        row_idx_d   = row_idx_q;
        row_data_d  = row_data_q;

        if (mat_clr) begin
            state_d     = EMPTY;
            half_vld_d  = 2'b00;
            err_d       = 1'b0;
            row_valid_d = 1'b0;
            row_idx_d   = '0;
        end else begin
            if (wr_ok)  half_vld_d[mat_a[AW-1]] = 1'b1;
            if (wr_bad) err_d = 1'b1;

            case (state_q)
                EMPTY: begin
                    if (&half_vld_d) state_d = READY;
                end
                READY: begin
                    if (start) begin
                        state_d     = STREAM;
                        row_valid_d = 1'b1;
                        row_idx_d   = '0;
                        row_data_d  = ram_row;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (row_idx_q == RIW'(ROWS - 1)) begin
                            state_d     = READY;
                            row_valid_d = 1'b0;
                            row_idx_d   = '0;
                        end else begin
                            row_idx_d  = rd_row;
                            row_data_d = ram_row;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        loaded_d = &half_vld_d;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            half_vld_q  <= 2'b00;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
            row_valid_q <= 1'b0;
            row_idx_q   <= '0;
            row_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            half_vld_q  <= half_vld_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
            row_valid_q <= row_valid_d;
            row_idx_q   <= row_idx_d;
            row_data_q  <= row_data_d;
        end
    end

    assign row_valid = row_valid_q;
    assign row_idx   = row_idx_q;
    assign row_data  = row_data_q;
    assign row_last  = row_valid_q && (row_idx_q == RIW'(ROWS - 1));
    assign loaded    = loaded_q;
    assign busy      = (state_q == STREAM);
    assign err       = err_q;

endmodule

// File: tb/tb_mat_core_buf.sv
// Scoreboard bench for mat_core_buf: a matrix-level reference model queues
// expected rows; a negedge monitor checks status and pops rows on handshake.
module tb_mat_core_buf;
    import mat_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                mat_clr = 1'b0;
    logic                mat_we = 1'b0;
    logic [AW-1:0]       mat_a = '0;
    logic [LANES*EW-1:0] mat_d = '0;
    logic                rd_start = 1'b0;
    logic                row_ready = 1'b0;
    logic                row_valid, row_last, loaded, busy, err;
    row_t                row_data;
    logic [RIW-1:0]      row_idx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mat_core_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mat_clr   (mat_clr),
        .mat_we    (mat_we),
        .mat_a     (mat_a),
        .mat_d     (mat_d),
        .rd_start  (rd_start),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_last  (row_last),
        .loaded    (loaded),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        int          idx;
        logic [63:0] data;
    } exp_row_t;

    exp_row_t   exp_q[$];
    logic [7:0] m_mem [64];
    bit         m_half0, m_half1, m_loaded, m_stream, m_err, m_was_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: matrix contents, half flags, and a queue of pending rows.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || mat_clr) begin
            m_half0 = 0; m_half1 = 0; m_loaded = 0; m_stream = 0; m_err = 0;
            exp_q.delete();
        end else begin
            m_was_ready = m_loaded && !m_stream;
            if (mat_we) begin
                if ((mat_a % 32) != 0 || m_stream) m_err = 1;
                else begin
                    for (int i = 0; i < 32; i++) m_mem[mat_a + i] = mat_d[i*8 +: 8];
                    if (mat_a == 0) m_half0 = 1; else m_half1 = 1;
                end
            end
            m_loaded = m_half0 && m_half1;
            if (m_stream && exp_q.size() == 0) m_stream = 0;
            if (rd_start && m_was_ready) begin
                for (int r = 0; r < 8; r++) begin
                    exp_row_t e;
                    e.idx = r;
                    for (int c = 0; c < 8; c++) e.data[c*8 +: 8] = m_mem[r*8 + c];
                    exp_q.push_back(e);
                end
                m_stream = 1;
            end
        end
    end

    // Monitor: compares outputs mid-cycle and retires a row on each handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            check("row_valid", 64'(row_valid), 64'(m_stream));
            check("busy", 64'(busy), 64'(m_stream));
            check("loaded", 64'(loaded), 64'(m_loaded));
            check("err", 64'(err), 64'(m_err));
            if (m_stream) begin
                if (exp_q.size() == 0) begin
                    check("row_queue_empty", 64'(1), 64'(0));
                end else begin
                    check("row_idx", 64'(row_idx), 64'(exp_q[0].idx));
                    check("row_data", row_data, exp_q[0].data);
                    check("row_last", 64'(row_last), 64'(exp_q[0].idx == 7));
                    if (row_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("row_last_idle", 64'(row_last), 64'(0));
            end
        end
    end

    task automatic drive(input logic clr, input logic we, input logic [AW-1:0] a,
                         input logic [LANES*EW-1:0] d, input logic st, input logic rdy);
        mat_clr = clr; mat_we = we; mat_a = a; mat_d = d; rd_start = st; row_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(0, 0, 0, '0, 0, rdy);
    endtask

    function automatic logic [LANES*EW-1:0] seq_beat(input int base);
        logic [LANES*EW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*8 +: 8] = 8'(base + i + 1);
        return d;
    endfunction

    function automatic logic [LANES*EW-1:0] rand_beat();
        logic [LANES*EW-1:0] d;
        for (int i = 0; i < LANES/4; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row_valid"}, 64'(row_valid), 0);
        check({tag, "_row_idx"}, 64'(row_idx), 0);
        check({tag, "_row_last"}, 64'(row_last), 0);
        check({tag, "_row_data"}, row_data, 0);
        check({tag, "_loaded"}, 64'(loaded), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_err"}, 64'(err), 0);
    endtask

    initial begin
        logic [LANES*EW-1:0] d;
        logic we, st;
        logic [AW-1:0] a;

        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed load, element e = e+1, then a full-speed stream.
        drive(0, 1, 0, seq_beat(0), 0, 1);
        check("loaded_after_first_half", 64'(loaded), 0);
        drive(0, 1, 32, seq_beat(32), 0, 1);
        check("loaded_after_second_half", 64'(loaded), 1);
        drive(0, 0, 0, '0, 1, 1);
        check("row0_valid", 64'(row_valid), 1);
        check("row0_data", row_data, 64'h0807060504030201);
        idle(10, 1);

        // Backpressure pattern 1,0,0,1,...
        drive(0, 0, 0, '0, 1, 1);
        for (int i = 0; i < 30; i++) drive(0, 0, 0, '0, 0, (i % 3) == 2);
        check("stream_drained", 64'(busy), 0);

        // Misaligned write sets err and leaves contents alone.
        drive(0, 1, 16, rand_beat(), 0, 0);
        check("err_misaligned", 64'(err), 1);
        drive(1, 0, 0, '0, 0, 0);
        check("err_cleared", 64'(err), 0);
        check("loaded_cleared", 64'(loaded), 0);

        // Partial load, then second half together with an ignored rd_start.
        drive(0, 1, 32, rand_beat(), 0, 1);
        drive(0, 0, 0, '0, 1, 1);
        check("partial_no_stream", 64'(row_valid), 0);
        drive(0, 1, 0, rand_beat(), 1, 1);
        check("start_with_last_write_ignored", 64'(row_valid), 0);
        drive(0, 0, 0, '0, 1, 1);
        // Write during the stream is dropped and flagged.
        drive(0, 1, 0, rand_beat(), 0, 1);
        check("err_write_in_stream", 64'(err), 1);
        idle(10, 1);

        // Clear at row 3 of a stream.
        drive(0, 0, 0, '0, 1, 1);
        idle(3, 1);
        check("row3_before_clear", 64'(row_idx), 3);
        drive(1, 0, 0, '0, 0, 0);
        check("clear_drops_valid", 64'(row_valid), 0);
        check("clear_drops_loaded", 64'(loaded), 0);
        drive(0, 0, 0, '0, 1, 1);
        drive(0, 1, 0, rand_beat(), 0, 1);
        drive(0, 0, 0, '0, 1, 1);
        check("start_half_loaded_ignored", 64'(row_valid), 0);
        drive(0, 1, 32, rand_beat(), 0, 1);
        drive(0, 0, 0, '0, 1, 0);
        idle(20, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 99) < 15);
            st = !we && ($urandom_range(0, 99) < 20);
            case ($urandom_range(0, 4))
                0, 1: a = 0;
                2, 3: a = 32;
                default: a = AW'($urandom_range(0, 63));
            endcase
            drive($urandom_range(0, 99) < 3, we, a, rand_beat(), st, $urandom_range(0, 1));
        end
        idle(20, 1);

        // Asynchronous reset mid-stream.
        drive(0, 1, 0, rand_beat(), 0, 1);
        drive(0, 1, 32, rand_beat(), 0, 1);
        drive(0, 0, 0, '0, 1, 1);
        idle(2, 1);
        check("busy_before_async_reset", 64'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        idle(2, 1);
        #2 rst_n = 1'b1;
        drive(0, 0, 0, '0, 1, 1);
        check("empty_after_reset_busy", 64'(busy), 0);
        check("empty_after_reset_valid", 64'(row_valid), 0);
        idle(3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mat_core_buf.md
Name: mat_core_buf

Overview:
- Per-core matrix buffer that sits directly downstream of the matrix-load controller. There are four instances, one per core.
- Captures an 8x8 matrix of EW-bit elements, delivered as two LANES-wide write beats at element addresses 0 and 32.
- After load, replays the matrix row by row over a valid/ready stream to the core's MAC datapath.
- The controller's per-core select bit drives mat_we. Its address drives mat_a. Its matw-low condition drives mat_clr.

Parameters:
- EW, 8, element width in bits
- LANES, 32, elements per write beat
- ROWS, 8, matrix rows
- COLS, 8, matrix columns; ROWS*COLS must equal 2*LANES

Ports:
- clk  in  1  system clock (AXIS_ACLK)
- rst_n  in  1  asynchronous active-low reset
- mat_clr  in  1  synchronous clear; invalidates contents and aborts any stream
- mat_we  in  1  write strobe (this core's select bit)
- mat_a  in  6  element base address of the beat (0 or 32)
- mat_d  in  LANES*EW  beat data; lane i is written to element mat_a+i
- rd_start  in  1  request to stream the loaded matrix
- row_valid  out  1  row_data is valid
- row_ready  in  1  downstream accepts the row
- row_data  out  COLS*EW  one row; column 0 in the LSBs
- row_idx  out  3  index of the row on row_data
- row_last  out  1  high with row 7
- loaded  out  1  both halves written since the last clear/reset
- busy  out  1  FSM is in STREAM
- err  out  1  sticky error flag; cleared by reset or mat_clr

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=EMPTY, half_vld=2'b00.
  - row_valid=0, row_idx=0, row_last=0, row_data=0, loaded=0, busy=0, err=0.
  - Array contents are not reset.
- Element e maps to row e/8, column e%8. Half h=mat_a[5].
- Write acceptance:
  - A write is accepted when mat_we=1, mat_clr=0, state!=STREAM and mat_a[4:0]==0.
  - On acceptance, all LANES elements of the half are written in one cycle and half_vld[h] is set.
- Write rejection:
  - mat_we with mat_a[4:0]!=0 is dropped and sets err.
  - mat_we while in STREAM is dropped and sets err. The stream continues unaffected.
- loaded = &half_vld, registered. It rises the cycle after the second half is written.
- States:
  - EMPTY -> READY when loaded becomes 1.
  - READY -> STREAM on rd_start=1 (and mat_clr=0). Row 0 is registered out: row_valid=1 and row_idx=0 in the next cycle. Latency is 1 cycle.
  - STREAM: a row advances only on row_valid&row_ready. row_data/row_idx stay stable while row_valid=1 and row_ready=0.
  - The handshake on row 7 (row_last=1) returns to READY with row_valid=0 the next cycle. Contents are retained, so a later rd_start replays the same matrix.
  - Back-to-back: rd_start in the same cycle as the final handshake is ignored. A new rd_start must arrive while in READY.
- rd_start while in EMPTY or STREAM is ignored; err is not set.
- Overwrite: an accepted write in READY updates that half and stays in READY. loaded stays 1.
- mat_clr=1 (synchronous, any state):
  - Next cycle: state=EMPTY, half_vld=0, loaded=0, row_valid=0, row_idx=0, row_last=0, busy=0, err=0.
  - mat_clr dominates a simultaneous mat_we or rd_start.
- Same cycle as the second-half write completing: rd_start is ignored, because loaded is not yet 1.
- Reset asserted mid-stream: outputs drop to reset values immediately (asynchronously).
- busy = (state==STREAM). row_last = row_valid & (row_idx==ROWS-1).

Decomposition:
- Package mat_pkg holds:
  - EW, LANES, ROWS, COLS
  - derived DEPTH=ROWS*COLS, AW=$clog2(DEPTH), RIW=$clog2(ROWS)
  - typedef buf_state_e {EMPTY, READY, STREAM}
  - typedefs elem_t and row_t.
- Sub-module mat_buf_ram:
  - 64xEW register array.
  - One half-wide write port selected by h.
  - One combinational row-read port indexed by row number.
- The parent mat_core_buf holds the FSM, half tracking, error logic and output register.

Test Plan:
- Load: element e=e+1 via write at mat_a=0 then mat_a=32 -> loaded=1 one cycle after the second beat. rd_start with row_ready=1 -> rows 0..7 on consecutive cycles; row 0 data 0x0807060504030201; row_last only with idx 7; then READY.
- Backpressure: row_ready toggled 1,0,0,1,... -> every row appears exactly once, and row_data/row_idx are held while stalled.
- Error cases:
  - write at mat_a=16 -> err=1, half_vld unchanged.
  - write during STREAM -> err=1, stream data is the original matrix.
  - mat_clr -> err=0.
- Partial load: only mat_a=32 written, then rd_start -> no row_valid, loaded=0. Write mat_a=0 in the same cycle as rd_start -> rd_start is ignored; a later rd_start streams.
- mat_clr at row 3 of a stream -> row_valid=0 and loaded=0 the next cycle. A following rd_start is ignored until both halves are reloaded.
- rst_n pulsed low mid-stream, asynchronously between clock edges -> outputs are immediately at reset values; after release, state is EMPTY.
